// File: rtl/opll_phase_gen_if.sv
// OPLL phase generator slot bus.
// Per-slot operands in, 10-bit phase out.
interface opll_phase_gen_if;
  logic       i_phi1_NCEN_n;
  logic       i_CYCLE_00;
  logic [3:0] i_TEST;
  logic [2:0] i_PMVAL;
  logic [8:0] i_FNUM;
  logic [2:0] i_BLOCK;
  logic [3:0] i_MUL;
  logic       i_PM;
  logic       i_PG_RST;
  logic [9:0] o_PHASE;

  modport master (
    output i_phi1_NCEN_n, i_CYCLE_00, i_TEST,
    output i_PMVAL, i_FNUM, i_BLOCK, i_MUL,
    output i_PM, i_PG_RST,
    input  o_PHASE
  );

  modport slave (
    input  i_phi1_NCEN_n, i_CYCLE_00, i_TEST,
    input  i_PMVAL, i_FNUM, i_BLOCK, i_MUL,
    input  i_PM, i_PG_RST,
    output o_PHASE
  );
endinterface

// File: rtl/opll_phase_gen.sv
// OPLL phase generator: vibrato, block/multiplier
// scaling and 18 rotating phase accumulators.
module opll_phase_gen #(
  parameter int SLOTS = 18,
  parameter int ACC_W = 19,
  parameter int OUT_W = 10
) (
  input  logic             i_EMUCLK,
  input  logic             i_RST,
  opll_phase_gen_if.slave  bus
);

  logic [2:0]       r_pmval;
  logic [ACC_W-1:0] r_acc [SLOTS];
  logic [OUT_W-1:0] r_phase;

  logic [2:0]       w_pmval;
  logic [2:0]       w_step;
  logic [2:0]       w_half;
  logic [2:0]       w_mag;
  logic             w_neg;
  logic [10:0]      w_f11;
  logic [17:0]      w_base;
  logic [4:0]       w_mult2;
  logic [22:0]      w_prod;
  logic [ACC_W-1:0] w_inc;
  logic [ACC_W-1:0] w_new;
  logic             w_unused;

  // slot 0 sees the fresh LFO value, the rest the latched one
  assign w_pmval = bus.i_CYCLE_00 ? bus.i_PMVAL : r_pmval;
  assign w_step  = bus.i_FNUM[8:6];
  assign w_half  = {1'b0, w_step[2:1]};

  // vibrato offset as magnitude plus sign
  always_comb begin
    w_mag = 3'd0;
    w_neg = 1'b0;
    unique case (w_pmval)
      3'd1, 3'd3: w_mag = w_half;
      3'd2:       w_mag = w_step;
      3'd5, 3'd7: begin
        w_mag = w_half;
        w_neg = 1'b1;
      end
      3'd6: begin
        w_mag = w_step;
        w_neg = 1'b1;
      end
      default: w_mag = 3'd0;
    endcase
    if (!bus.i_PM) begin
      w_mag = 3'd0;
      w_neg = 1'b0;
    end
  end

  assign w_f11 = w_neg
    ? ({1'b0, bus.i_FNUM, 1'b0} - {8'd0, w_mag})
    : ({1'b0, bus.i_FNUM, 1'b0} + {8'd0, w_mag});

  assign w_base = {7'd0, w_f11} << bus.i_BLOCK;

  // multiplier code to twice the frequency ratio
  always_comb begin
    w_mult2 = 5'd1;
    unique case (bus.i_MUL)
      4'd0:  w_mult2 = 5'd1;
      4'd1:  w_mult2 = 5'd2;
      4'd2:  w_mult2 = 5'd4;
      4'd3:  w_mult2 = 5'd6;
      4'd4:  w_mult2 = 5'd8;
      4'd5:  w_mult2 = 5'd10;
      4'd6:  w_mult2 = 5'd12;
      4'd7:  w_mult2 = 5'd14;
      4'd8:  w_mult2 = 5'd16;
      4'd9:  w_mult2 = 5'd18;
      4'd10: w_mult2 = 5'd20;
      4'd11: w_mult2 = 5'd20;
      4'd12: w_mult2 = 5'd24;
      4'd13: w_mult2 = 5'd24;
      4'd14: w_mult2 = 5'd30;
      default: w_mult2 = 5'd30;
    endcase
  end

  assign w_prod = {5'd0, w_base} * {18'd0, w_mult2};
  assign w_inc  = w_prod[ACC_W+1:2];

  assign w_new = (bus.i_PG_RST | bus.i_TEST[1])
    ? '0 : r_acc[0] + w_inc;

  assign w_unused = ^{bus.i_TEST[3:2], bus.i_TEST[0],
                      w_prod[22:21], w_prod[1:0]};

  // PMVAL latch, loaded at the start of each frame
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST)
      r_pmval <= 3'd0;
    else if (!bus.i_phi1_NCEN_n && bus.i_CYCLE_00)
      r_pmval <= bus.i_PMVAL;
  end

  // accumulator ring: head is the current slot, new goes to tail
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      for (int i = 0; i < SLOTS; i++)
        r_acc[i] <= '0;
    end else if (!bus.i_phi1_NCEN_n) begin
      for (int i = 0; i < SLOTS-1; i++)
        r_acc[i] <= r_acc[i+1];
      r_acc[SLOTS-1] <= w_new;
    end
  end

  // output register, one enable behind the slot
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST)
      r_phase <= '0;
    else if (!bus.i_phi1_NCEN_n)
      r_phase <= w_new[ACC_W-1:ACC_W-OUT_W];
  end

  assign bus.o_PHASE = r_phase;

endmodule

// File: tb/tb_opll_phase_gen.sv
// Bench for opll_phase_gen: directed frames,
// scoreboard queue checked by a separate monitor.
module tb_opll_phase_gen;

  logic clk;
  logic rst;
  opll_phase_gen_if bus();

  opll_phase_gen dut (
    .i_EMUCLK (clk),
    .i_RST    (rst),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int exp_q[$];
  int total = 0;
  int bad   = 0;
  int acc [18];
  int last  = 0;
  int nslot = 0;

  // monitor: one expected value per clock
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        int e;
        e = exp_q.pop_front();
        total++;
        if (int'(bus.o_PHASE) != e) begin
          bad++;
          $display("FAIL phase n=%0d got=%0d exp=%0d",
                   total, bus.o_PHASE, e);
        end
      end
    end
  end

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = 1'b1;
      bus.i_phi1_NCEN_n = 1'b0;
      exp_q.push_back(0);
    end
    for (int i = 0; i < 18; i++) acc[i] = 0;
    last  = 0;
    nslot = 0;
  endtask

  task automatic idle();
    @(negedge clk);
    rst = 1'b0;
    bus.i_phi1_NCEN_n = 1'b1;
    exp_q.push_back(last);
  endtask

  task automatic slot(
    input [8:0] fn, input [2:0] bl, input [3:0] mu,
    input pm, input [2:0] pv, input pg, input t1,
    input int inc);
    @(negedge clk);
    rst = 1'b0;
    bus.i_phi1_NCEN_n = 1'b0;
    bus.i_CYCLE_00 = (nslot == 0);
    bus.i_FNUM   = fn;
    bus.i_BLOCK  = bl;
    bus.i_MUL    = mu;
    bus.i_PM     = pm;
    bus.i_PMVAL  = pv;
    bus.i_PG_RST = pg;
    bus.i_TEST   = {2'b00, t1, 1'b0};
    if (pg || t1) acc[nslot] = 0;
    else acc[nslot] = (acc[nslot] + inc) % 524288;
    last = acc[nslot] >> 9;
    exp_q.push_back(last);
    nslot = (nslot + 1) % 18;
  endtask

  task automatic frame(
    input [8:0] fn, input [2:0] bl, input [3:0] mu,
    input pm, input [2:0] pva, input [2:0] pvb,
    input int pgs, input t1, input int inc);
    for (int s = 0; s < 18; s++)
      slot(fn, bl, mu, pm, (s < 9) ? pva : pvb,
           (s == pgs), t1, inc);
  endtask

  task automatic vib(input pm, input [2:0] pv,
                     input int inc);
    for (int f = 0; f < 8; f++)
      frame(9'd448, 3'd7, 4'd1, pm, pv, pv, -1, 1'b0, inc);
    frame(9'd448, 3'd7, 4'd1, pm, pv, pv, -1, 1'b1, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_phi1_NCEN_n = 1'b1;
    bus.i_CYCLE_00 = 1'b0;
    bus.i_TEST   = 4'd0;
    bus.i_PMVAL  = 3'd0;
    bus.i_FNUM   = 9'd0;
    bus.i_BLOCK  = 3'd0;
    bus.i_MUL    = 4'd0;
    bus.i_PM     = 1'b0;
    bus.i_PG_RST = 1'b0;

    do_reset(2);
    for (int s = 0; s < 9; s++)
      slot(9'd256, 3'd4, 4'd1, 1'b0, 3'd0, 1'b0, 1'b0, 4096);
    do_reset(3);

    for (int f = 0; f < 128; f++) begin
      frame(9'd256, 3'd4, 4'd1, 1'b0, 3'd0, 3'd0,
            -1, 1'b0, 4096);
      if (f == 50) idle();
    end

    frame(9'd511, 3'd7, 4'd15, 1'b1, 3'd2, 3'd2,
          -1, 1'b0, 463552);
    frame(9'd511, 3'd7, 4'd15, 1'b1, 3'd2, 3'd2,
          -1, 1'b0, 463552);
    frame(9'd511, 3'd7, 4'd15, 1'b1, 3'd2, 3'd2,
          -1, 1'b1, 0);

    vib(1'b1, 3'd2, 57792);
    vib(1'b1, 3'd1, 57536);
    vib(1'b1, 3'd0, 57344);
    vib(1'b1, 3'd6, 56896);
    vib(1'b0, 3'd2, 57344);
    vib(1'b0, 3'd6, 57344);

    frame(9'd448, 3'd7, 4'd1, 1'b1, 3'd2, 3'd6,
          -1, 1'b0, 57792);
    for (int f = 0; f < 7; f++)
      frame(9'd448, 3'd7, 4'd1, 1'b1, 3'd6, 3'd6,
            -1, 1'b0, 56896);
    frame(9'd448, 3'd7, 4'd1, 1'b1, 3'd6, 3'd6,
          -1, 1'b1, 0);

    for (int f = 0; f < 3; f++)
      frame(9'd256, 3'd4, 4'd1, 1'b0, 3'd0, 3'd0,
            -1, 1'b0, 4096);
    frame(9'd256, 3'd4, 4'd1, 1'b0, 3'd0, 3'd0,
          5, 1'b0, 4096);
    frame(9'd256, 3'd4, 4'd1, 1'b0, 3'd0, 3'd0,
          -1, 1'b0, 4096);

    idle();
    repeat (4) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
